// File: rtl/read_seq_fetcher_pkg.sv
// Shared types and constants for the read/D(i) ROM fetcher.
package read_seq_fetcher_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned SW_DEF = 2;

  localparam logic [1:0] SYM_A = 2'b00;
  localparam logic [1:0] SYM_C = 2'b01;
  localparam logic [1:0] SYM_G = 2'b10;
  localparam logic [1:0] SYM_T = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/read_seq_fetcher.sv
// Walks one read in the symbol/D(i) ROM and streams {idx, sym, D(i)} over valid/ready.
module read_seq_fetcher
  import read_seq_fetcher_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned SW      = SW_DEF,
  parameter bit          DESCEND = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] read_len,
  output logic          busy,
  output logic          done,
  output logic          rom_ce,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_d_i,
  input  logic [SW-1:0] rom_read_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [SW-1:0] out_sym,
  output logic [DW-1:0] out_d,
  output logic          out_last
);

  state_e        r_state;
  state_e        w_state_d;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_rem;
  logic          r_out_valid;
  logic          r_out_last;
  logic [AW-1:0] r_out_idx;
  logic [SW-1:0] r_out_sym;
  logic [DW-1:0] r_out_d;
  logic          w_load;
  logic          w_last_hs;
  logic          w_accept;

  assign w_accept  = (r_state == StIdle) && start;
  // Output register refills whenever it is empty or being drained this cycle.
  assign w_load    = (r_state == StRun) && (!r_out_valid || out_ready);
  assign w_last_hs = (r_state == StDrain) && r_out_valid && out_ready && r_out_last;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = (read_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (w_load && (r_rem == AW'(1))) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_last_hs) begin
          w_state_d = StDone;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_idx  <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_base <= base_addr;
      r_idx  <= DESCEND ? (read_len - AW'(1)) : '0;
      r_rem  <= read_len;
    end else if (w_load) begin
      r_idx  <= DESCEND ? (r_idx - AW'(1)) : (r_idx + AW'(1));
      r_rem  <= r_rem - AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
      r_out_sym   <= '0;
      r_out_d     <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_last  <= (r_rem == AW'(1));
      r_out_idx   <= r_idx;
      r_out_sym   <= rom_read_i;
      r_out_d     <= rom_d_i;
    end else if (w_last_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  always_comb begin
    busy     = (r_state != StIdle);
    done     = (r_state == StDone);
    rom_ce   = (r_state == StRun);
    // Address wraps modulo 2^AW by truncation.
    rom_addr = (r_state == StRun) ? (r_base + r_idx) : '0;
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_idx   = r_out_idx;
  assign out_sym   = r_out_sym;
  assign out_d     = r_out_d;

endmodule
